// File: rtl/reg_status_table.sv
`default_nettype none
// ============================================================================
// Module   : reg_status_table
// Purpose  : Per-register producer scoreboard (busy/done/tag) for 31 scalar
//            registers, with a writeback bypass on the source lookups.
// Revision : 1.0 - initial release
// ============================================================================
module reg_status_table #(
    parameter  int NUM_ENTRY = 16,
    parameter  int NUM_WB    = 4,
    localparam int IDXW      = $clog2(NUM_ENTRY)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   dispatch_ena,
    input  logic                   dispatch_wen,
    input  logic [4:0]             dispatch_rd,
    input  logic [IDXW-1:0]        dispatch_tag,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [NUM_WB-1:0]      wb_ready,
    input  logic [NUM_WB*IDXW-1:0] wb_index,
    input  logic                   commit_ena,
    input  logic [4:0]             commit_rd,
    input  logic [IDXW-1:0]        commit_tag,
    input  logic                   flush,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   rs1_done,
    output logic                   rs2_done,
    output logic [IDXW-1:0]        rs1_tag,
    output logic [IDXW-1:0]        rs2_tag,
    output logic                   raw_hazard,
    output logic [5:0]             busy_count
);

    // Entry 0 is never written, so x0 always reads as idle.
    logic [31:0]     busy_q, busy_d;
    logic [31:0]     done_q, done_d;
    logic [IDXW-1:0] tag_q [32];
    logic [IDXW-1:0] tag_d [32];
    logic [31:0]     wb_hit;
    logic            dispatch_we;
    logic            commit_hit;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            wb_hit[r] = 1'b0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_ready[p] && (wb_index[p*IDXW +: IDXW] == tag_q[r])) begin
                    wb_hit[r] = 1'b1;
                end
            end
        end
    end

    assign dispatch_we = dispatch_ena && dispatch_wen && (dispatch_rd != 5'd0);
    assign commit_hit  = commit_ena && (commit_rd != 5'd0) && busy_q[commit_rd]
                         && (tag_q[commit_rd] == commit_tag);

    // Later assignments win: writeback, then commit, then dispatch, then flush.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        tag_d  = tag_q;
        for (int r = 1; r < 32; r++) begin
            if (busy_q[r] && wb_hit[r]) begin
                done_d[r] = 1'b1;
            end
        end
        if (commit_hit) begin
            busy_d[commit_rd] = 1'b0;
            done_d[commit_rd] = 1'b0;
            tag_d[commit_rd]  = '0;
        end
        if (dispatch_we) begin
            busy_d[dispatch_rd] = 1'b1;
            done_d[dispatch_rd] = 1'b0;
            tag_d[dispatch_rd]  = dispatch_tag;
        end
        if (flush) begin
            busy_d = '0;
            done_d = '0;
            tag_d  = '{default: '0};
        end
        busy_d[0] = 1'b0;
        done_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= '0;
            done_q <= '0;
            tag_q  <= '{default: '0};
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            tag_q  <= tag_d;
        end
    end

    // Lookups see the current state plus same-cycle broadcasts, not dispatch.
    assign rs1_busy   = busy_q[rs1];
    assign rs2_busy   = busy_q[rs2];
    assign rs1_done   = done_q[rs1] | (busy_q[rs1] & wb_hit[rs1]);
    assign rs2_done   = done_q[rs2] | (busy_q[rs2] & wb_hit[rs2]);
    assign rs1_tag    = busy_q[rs1] ? tag_q[rs1] : '0;
    assign rs2_tag    = busy_q[rs2] ? tag_q[rs2] : '0;
    assign raw_hazard = (rs1_busy & ~rs1_done) | (rs2_busy & ~rs2_done);

    always_comb begin
        busy_count = 6'd0;
        for (int r = 1; r < 32; r++) begin
            busy_count = busy_count + {5'd0, busy_q[r]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_status_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_status_table
// Purpose  : Directed and random checks of reg_status_table against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_status_table;

    localparam int NUM_ENTRY = 16;
    localparam int NUM_WB    = 4;
    localparam int IDXW      = 4;

    logic                   CLK;
    logic                   RST;
    logic                   dispatch_ena;
    logic                   dispatch_wen;
    logic [4:0]             dispatch_rd;
    logic [IDXW-1:0]        dispatch_tag;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [NUM_WB-1:0]      wb_ready;
    logic [NUM_WB*IDXW-1:0] wb_index;
    logic                   commit_ena;
    logic [4:0]             commit_rd;
    logic [IDXW-1:0]        commit_tag;
    logic                   flush;
    logic                   rs1_busy, rs2_busy, rs1_done, rs2_done;
    logic [IDXW-1:0]        rs1_tag, rs2_tag;
    logic                   raw_hazard;
    logic [5:0]             busy_count;

    int tests = 0;
    int fails = 0;

    bit m_busy [32];
    bit m_done [32];
    int m_tag  [32];

    reg_status_table #(.NUM_ENTRY(NUM_ENTRY), .NUM_WB(NUM_WB)) dut (
        .CLK(CLK), .RST(RST),
        .dispatch_ena(dispatch_ena), .dispatch_wen(dispatch_wen),
        .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
        .rs1(rs1), .rs2(rs2),
        .wb_ready(wb_ready), .wb_index(wb_index),
        .commit_ena(commit_ena), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .flush(flush),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_done(rs1_done), .rs2_done(rs2_done),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .raw_hazard(raw_hazard), .busy_count(busy_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit wb_match(input int t);
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_ready[p] && (int'(wb_index[p*IDXW +: IDXW]) == t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic settle();
        bit b1, b2, d1, d2;
        int t1, t2, cnt;
        #1;
        b1  = (rs1 != 0) && m_busy[rs1];
        b2  = (rs2 != 0) && m_busy[rs2];
        d1  = (rs1 != 0) && (m_done[rs1] || (m_busy[rs1] && wb_match(m_tag[rs1])));
        d2  = (rs2 != 0) && (m_done[rs2] || (m_busy[rs2] && wb_match(m_tag[rs2])));
        t1  = b1 ? m_tag[rs1] : 0;
        t2  = b2 ? m_tag[rs2] : 0;
        cnt = 0;
        for (int r = 1; r < 32; r++) cnt += int'(m_busy[r]);
        chk("rs1_busy", 32'(rs1_busy), 32'(b1));
        chk("rs2_busy", 32'(rs2_busy), 32'(b2));
        chk("rs1_done", 32'(rs1_done), 32'(d1));
        chk("rs2_done", 32'(rs2_done), 32'(d2));
        chk("rs1_tag", 32'(rs1_tag), 32'(t1));
        chk("rs2_tag", 32'(rs2_tag), 32'(t2));
        chk("raw_hazard", 32'(raw_hazard), 32'((b1 && !d1) || (b2 && !d2)));
        chk("busy_count", 32'(busy_count), 32'(cnt));
    endtask

    // Apply the registered update rules to the model at the clock edge.
    task automatic tick();
        bit nb [32];
        bit nd [32];
        int nt [32];
        @(posedge CLK);
        nb = m_busy; nd = m_done; nt = m_tag;
        if (RST || flush) begin
            for (int r = 0; r < 32; r++) begin nb[r] = 0; nd[r] = 0; nt[r] = 0; end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (m_busy[r] && wb_match(m_tag[r])) nd[r] = 1;
            end
            if (commit_ena && commit_rd != 0 && m_busy[commit_rd]
                && m_tag[commit_rd] == int'(commit_tag)) begin
                nb[commit_rd] = 0; nd[commit_rd] = 0; nt[commit_rd] = 0;
            end
            if (dispatch_ena && dispatch_wen && dispatch_rd != 0) begin
                nb[dispatch_rd] = 1; nd[dispatch_rd] = 0; nt[dispatch_rd] = int'(dispatch_tag);
            end
        end
        m_busy = nb; m_done = nd; m_tag = nt;
        @(negedge CLK);
    endtask

    task automatic idle();
        RST = 0; dispatch_ena = 0; dispatch_wen = 0; dispatch_rd = 0; dispatch_tag = 0;
        rs1 = 0; rs2 = 0; wb_ready = 0; wb_index = 0;
        commit_ena = 0; commit_rd = 0; commit_tag = 0; flush = 0;
    endtask

    task automatic disp(input int rd, input int tag);
        dispatch_ena = 1; dispatch_wen = 1; dispatch_rd = 5'(rd); dispatch_tag = IDXW'(tag);
    endtask

    task automatic commit(input int rd, input int tag);
        commit_ena = 1; commit_rd = 5'(rd); commit_tag = IDXW'(tag);
    endtask

    initial begin
        idle();
        RST = 1;
        for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_done[r] = 0; m_tag[r] = 0; end
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        rs1 = 5; rs2 = 9;
        settle();
        chk("reset_count", 32'(busy_count), 32'd0);
        tick();

        // Basic dispatch then lookup
        idle(); disp(5, 3); rs1 = 5; settle();
        chk("no_dispatch_bypass", 32'(rs1_busy), 32'd0);
        tick();
        idle(); rs1 = 5; settle();
        chk("d_busy", 32'(rs1_busy), 32'd1);
        chk("d_tag", 32'(rs1_tag), 32'd3);
        chk("d_raw", 32'(raw_hazard), 32'd1);
        chk("d_count", 32'(busy_count), 32'd1);
        tick();

        // Writeback bypass on port 2
        idle(); rs2 = 5; wb_ready = 4'b0100; wb_index[2*IDXW +: IDXW] = 4'd3; settle();
        chk("wb_bypass_done", 32'(rs2_done), 32'd1);
        chk("wb_bypass_raw", 32'(raw_hazard), 32'd0);
        tick();
        idle(); rs2 = 5; settle();
        chk("wb_latched", 32'(rs2_done), 32'd1);
        tick();

        // Dispatch overrides commit of the old tag
        idle(); disp(5, 7); commit(5, 3); settle(); tick();
        idle(); rs1 = 5; settle();
        chk("prio_busy", 32'(rs1_busy), 32'd1);
        chk("prio_tag", 32'(rs1_tag), 32'd7);
        chk("prio_done", 32'(rs1_done), 32'd0);
        tick();

        // Stale commit ignored, matching commit retires
        idle(); commit(5, 3); settle(); tick();
        idle(); rs1 = 5; settle();
        chk("stale_commit", 32'(rs1_tag), 32'd7);
        tick();
        idle(); commit(5, 7); settle(); tick();
        idle(); rs1 = 5; settle();
        chk("commit_clear", 32'(busy_count), 32'd0);
        tick();

        // x0 never busy; flush wins over dispatch
        idle(); disp(0, 2); settle(); tick();
        idle(); rs1 = 0; settle();
        chk("x0_busy", 32'(rs1_busy), 32'd0);
        chk("x0_count", 32'(busy_count), 32'd0);
        tick();
        for (int i = 1; i <= 10; i++) begin idle(); disp(i, i); settle(); tick(); end
        idle(); settle();
        chk("ten_busy", 32'(busy_count), 32'd10);
        tick();
        idle(); flush = 1; disp(9, 4); settle(); tick();
        idle(); rs1 = 9; settle();
        chk("flush_count", 32'(busy_count), 32'd0);
        tick();

        // Tag wrap 15 -> 0, then reset mid-stream
        idle(); disp(1, 15); settle(); tick();
        idle(); disp(2, 0); settle(); tick();
        idle(); wb_ready = 4'b0001; wb_index = '0; settle(); tick();
        idle(); rs1 = 1; rs2 = 2; settle();
        chk("wrap_x1_done", 32'(rs1_done), 32'd0);
        chk("wrap_x2_done", 32'(rs2_done), 32'd1);
        tick();
        idle(); RST = 1; disp(3, 5); commit(1, 15); settle(); tick();
        idle(); rs1 = 1; rs2 = 3; settle();
        chk("rst_count", 32'(busy_count), 32'd0);
        chk("rst_tag", 32'(rs1_tag), 32'd0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int crd;
            idle();
            RST          = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 39) == 0);
            dispatch_ena = ($urandom_range(0, 3) != 0);
            dispatch_wen = ($urandom_range(0, 4) != 0);
            dispatch_rd  = 5'($urandom_range(0, 31));
            dispatch_tag = IDXW'($urandom_range(0, NUM_ENTRY - 1));
            rs1          = 5'($urandom_range(0, 31));
            rs2          = 5'($urandom_range(0, 31));
            wb_ready     = NUM_WB'($urandom);
            wb_index     = (NUM_WB*IDXW)'($urandom);
            crd          = $urandom_range(0, 31);
            commit_ena   = ($urandom_range(0, 2) != 0);
            commit_rd    = 5'(crd);
            commit_tag   = ($urandom_range(0, 9) < 7) ? IDXW'(m_tag[crd])
                                                      : IDXW'($urandom_range(0, NUM_ENTRY - 1));
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_status_table.md
REG_STATUS_TABLE -- requirements
Module: reg_status_table

Interface
REQ-001 Parameter: NUM_ENTRY, default 16, completion-buffer depth; IDXW = $clog2(NUM_ENTRY).
REQ-002 Parameter: NUM_WB, default 4, number of result-broadcast ports (arith, mul, div, load/store).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 dispatch_ena  in  1  instruction allocated in completion buffer this cycle.
REQ-006 dispatch_wen  in  1  dispatched instruction writes a scalar register.
REQ-007 dispatch_rd  in  5  destination register of dispatched instruction.
REQ-008 dispatch_tag  in  IDXW  completion-buffer entry (current tail) assigned to dispatched instruction.
REQ-009 rs1, rs2  in  5 each  source registers of instruction at dispatch.
REQ-010 wb_ready  in  NUM_WB  per-port result-written-to-buffer strobe.
REQ-011 wb_index  in  NUM_WB*IDXW  per-port buffer entry index, port p at bits [p*IDXW +: IDXW].
REQ-012 commit_ena  in  1  head entry retires with register write this cycle.
REQ-013 commit_rd  in  5; commit_tag  in  IDXW  register and buffer entry of retiring instruction.
REQ-014 flush  in  1  pipeline flush (exception, mispredict).
REQ-015 rs1_busy, rs2_busy  out  1 each  source has an in-flight producer.
REQ-016 rs1_done, rs2_done  out  1 each  producer result already in buffer, or broadcast this cycle.
REQ-017 rs1_tag, rs2_tag  out  IDXW each  buffer entry of producer; 0 when not busy.
REQ-018 raw_hazard  out  1  (rs1_busy & ~rs1_done) | (rs2_busy & ~rs2_done).
REQ-019 busy_count  out  6  number of registers with busy set.

Function
REQ-020 State per register r in 1..31: busy, done, tag[IDXW]; register 0 has no state and reads busy=0, done=0, tag=0.
REQ-021 Lookups are combinational on current state plus same-cycle wb bypass; they do not see the same-cycle dispatch write (rs==rd reads prior producer).
REQ-022 rsN_done = done[rsN] | (busy[rsN] & any p: wb_ready[p] & wb_index[p]==tag[rsN]).
REQ-023 Dispatch: dispatch_ena & dispatch_wen & dispatch_rd!=0 -> next cycle busy=1, done=0, tag=dispatch_tag for dispatch_rd.
REQ-024 Writeback: each busy register whose tag matches any ready wb port sets done=1 next cycle; multiple ports matching same tag is legal, no error.
REQ-025 Commit: commit_ena & commit_rd!=0 & busy[commit_rd] & tag[commit_rd]==commit_tag -> clears busy, done, tag next cycle; tag mismatch (newer writer) -> no change.
REQ-026 Same-cycle priority per register: dispatch > commit > writeback; dispatch to a register overrides commit/wb of its old tag.
REQ-027 Dispatch with dispatch_rd==0 or dispatch_wen==0 changes no state.
REQ-028 flush=1 -> all busy, done, tag cleared next cycle; dispatch, commit, wb in the same cycle ignored.
REQ-029 Tags wrap modulo NUM_ENTRY; no comparison depends on tag order, only equality.
REQ-030 busy_count = combinational popcount of busy[31:1], range 0..31.

Reset
REQ-031 RST=1 at a rising edge clears all busy, done, tag; RST has priority over flush and all updates.
REQ-032 After reset: all rsN_busy=0, rsN_done=0, rsN_tag=0, raw_hazard=0, busy_count=0.
REQ-033 RST asserted mid-operation discards all in-flight state in one cycle; no partial retention.

Verification
REQ-034 Dispatch rd=5 tag=3; next cycle rs1=5 -> rs1_busy=1, rs1_done=0, rs1_tag=3, raw_hazard=1, busy_count=1.
REQ-035 With x5 busy tag 3, wb_ready[2]=1 wb_index[2]=3, rs2=5 same cycle -> rs2_done=1, raw_hazard=0; next cycle done latched.
REQ-036 x5 tag 3, dispatch rd=5 tag=7 and commit rd=5 tag=3 same cycle -> next cycle x5 busy=1, tag=7, done=0.
REQ-037 x5 tag 7, commit rd=5 tag=3 -> x5 unchanged; then commit rd=5 tag=7 -> busy=0, busy_count decrements.
REQ-038 Dispatch rd=0 tag=2, rs1=0 -> rs1_busy=0, busy_count=0; 10 registers busy then flush=1 with dispatch rd=9 -> next cycle busy_count=0.
REQ-039 Tag wrap: dispatch tags 15 then 0 to x1, x2; wb_index=0 sets only x2 done; RST mid-stream -> all outputs 0 next cycle.
